cpu_if_timeout_mon: RTL and testbench
=====================================

CPU_IF_TIMEOUT_MON -- requirements
Module: cpu_if_timeout_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent request/acknowledge channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the per-channel timeout counter and of the limit port.
REQ-003 SHALL have parameter RESTART_ON_REQ, default 0, meaning that when 1, a req seen while the channel is waiting restarts its counter; when 0, that req is ignored.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port limit  input  CNT_W  timeout threshold in cycles, shared by all channels; 0 disables timeout.
REQ-007 SHALL have port req  input  NUM_CH  per-channel transaction start; any cycle high is one request.
REQ-008 SHALL have port ack  input  NUM_CH  per-channel transaction completion.
REQ-009 SHALL have port clr  input  NUM_CH  per-channel abort/clear of state and sticky flag.
REQ-010 SHALL have port busy  output  NUM_CH  registered; high while the channel is in WAIT.
REQ-011 SHALL have port timeout_pulse  output  NUM_CH  registered; high for exactly one cycle on entry to TIMEOUT.
REQ-012 SHALL have port timeout_sticky  output  NUM_CH  registered; high while the channel is in TIMEOUT.
REQ-013 SHALL have port any_timeout  output  1  registered OR of all timeout_sticky bits.
REQ-014 SHALL have port first_ch  output  max(1,$clog2(NUM_CH))  registered; index of the lowest-numbered channel with timeout_sticky set; 0 when none is set.

Function
REQ-015 Each channel SHALL implement the FSM IDLE, WAIT, TIMEOUT.
REQ-016 Priority order per channel SHALL be clr > ack > expiry > req.
REQ-017 IDLE: req=1 (and clr=0) -> WAIT with counter=0; ack alone in IDLE is ignored.
REQ-018 WAIT: ack=1 -> IDLE; otherwise counter increments by 1, saturating at 2^CNT_W-1.
REQ-019 WAIT expiry: limit!=0, no ack, and counter >= limit-1 -> TIMEOUT; the timeout_pulse asserts limit edges after the req-sampling edge.
REQ-020 ack sampled on the expiry edge SHALL win: the channel goes to IDLE and no pulse occurs.
REQ-021 WAIT with req=1 and no ack/expiry: counter := 0 if RESTART_ON_REQ=1, else req is ignored.
REQ-022 limit is compared live: lowering it below the current count causes expiry on the next edge; limit=0 in WAIT never expires.
REQ-023 TIMEOUT: req and ack are ignored; only clr or reset leaves it, going to IDLE.
REQ-024 clr in any state -> IDLE with counter=0 on the next edge; clr together with req does not start a transaction.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels do not interact.
REQ-026 any_timeout and first_ch SHALL be derived from the next-state sticky bits, so they are cycle-aligned with timeout_sticky.

Reset
REQ-027 reset=1 at a clock edge SHALL force all channels to IDLE with counter=0, and busy=0, timeout_pulse=0, timeout_sticky=0, any_timeout=0, first_ch=0.
REQ-028 reset SHALL override req/ack/clr, including mid-WAIT and in TIMEOUT.
REQ-029 Normal operation SHALL resume on the first edge with reset=0, and req is honoured on that edge.

Structure
REQ-030 A package cpu_if_timeout_pkg SHALL hold the state enum (IDLE, WAIT, TIMEOUT) and the default constants for NUM_CH and CNT_W.
REQ-031 The per-channel FSM and counter SHALL be the sub-module cpu_if_timeout_ch, instantiated NUM_CH times by a generate loop.
REQ-032 The top level SHALL hold only the any_timeout/first_ch reduction logic.

Verification
REQ-033 limit=4, req[0] at edge 0, no ack -> busy[0] is high after edges 1-3, timeout_pulse[0] is high for one cycle after edge 4, and timeout_sticky[0] and any_timeout stay 1; first_ch=0.
REQ-034 limit=4, req[1] at edge 0, ack[1] at edge 4 -> no pulse; busy[1] drops after edge 4.
REQ-035 limit=0, req[2], hold 300 cycles with no ack -> busy[2] remains 1 and no timeout occurs; then ack -> IDLE.
REQ-036 Channels 1 and 3 time out on the same edge -> first_ch=1; after clr[1], first_ch=3; after clr[3], any_timeout=0 and first_ch=0.
REQ-037 RESTART_ON_REQ=1, limit=5, req at edges 0 and 3 -> pulse after edge 8; with RESTART_ON_REQ=0 the pulse comes after edge 5.
REQ-038 reset at edge 2 of WAIT, and separately in TIMEOUT -> all outputs 0 the next cycle; req on the first edge after reset is accepted.

Source files
------------

// File: rtl/cpu_if_timeout_pkg.sv
// Shared types and defaults for the request/acknowledge timeout monitor.
// Holds the per-channel state encoding and the index-width helper.
package cpu_if_timeout_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_if_timeout_mon_if.sv
// Bus bundle between a CPU-side driver and the timeout monitor.
// Handshake: req high on a sampled edge opens one transaction; ack high on a later edge closes it; clr aborts.
interface cpu_if_timeout_mon_if
    import cpu_if_timeout_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int IDX_W = idx_w(NUM_CH);

    logic [CNT_W-1:0]  limit;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] timeout_pulse;
    logic [NUM_CH-1:0] timeout_sticky;
    logic              any_timeout;
    logic [IDX_W-1:0]  first_ch;
    state_t            dbg_state [NUM_CH];

    modport master (
        output limit, req, ack, clr,
        input  busy, timeout_pulse, timeout_sticky, any_timeout, first_ch, dbg_state
    );

    modport slave (
        input  limit, req, ack, clr,
        output busy, timeout_pulse, timeout_sticky, any_timeout, first_ch, dbg_state
    );

endinterface

// File: rtl/cpu_if_timeout_ch.sv
// One channel of the timeout monitor: IDLE/WAIT/TIMEOUT FSM with a saturating wait counter.
// Priority inside the channel is clr, then ack, then expiry, then req.
module cpu_if_timeout_ch
    import cpu_if_timeout_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter bit RESTART_ON_REQ = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_limit,
    input  logic             i_req,
    input  logic             i_ack,
    input  logic             i_clr,
    output logic             o_busy,
    output logic             o_pulse,
    output logic             o_sticky,
    output logic             o_sticky_nxt,
    output state_t           o_state
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy, r_pulse, r_sticky;
    logic             w_busy_nxt, w_pulse_nxt, w_sticky_nxt;
    logic             w_expire;

    // Limit is compared live, so lowering it mid-wait expires on the next edge.
    assign w_expire = (i_limit != '0) && (r_cnt >= i_limit - CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_pulse  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_pulse  <= w_pulse_nxt;
            r_sticky <= w_sticky_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_clr) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                WAIT: begin
                    if (i_ack) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_expire) begin
                        w_state_nxt = TIMEOUT;
                    end else if (i_req && RESTART_ON_REQ) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                TIMEOUT: begin
                    w_state_nxt = TIMEOUT;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_busy_nxt   = (w_state_nxt == WAIT);
        w_sticky_nxt = (w_state_nxt == TIMEOUT);
        w_pulse_nxt  = (r_state == WAIT) && (w_state_nxt == TIMEOUT);
    end

    assign o_busy       = r_busy;
    assign o_pulse      = r_pulse;
    assign o_sticky     = r_sticky;
    assign o_sticky_nxt = w_sticky_nxt;
    assign o_state      = r_state;

endmodule

// File: rtl/cpu_if_timeout_mon.sv
// Multi-channel request/acknowledge timeout monitor.
// Channels run independently; the top only reduces their sticky flags to any_timeout / first_ch.
module cpu_if_timeout_mon
    import cpu_if_timeout_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int CNT_W          = DEF_CNT_W,
    parameter bit RESTART_ON_REQ = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    cpu_if_timeout_mon_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_pulse;
    logic [NUM_CH-1:0] w_sticky;
    logic [NUM_CH-1:0] w_sticky_nxt;
    state_t            w_state [NUM_CH];
    logic [IDX_W-1:0]  w_first;
    logic              r_any;
    logic [IDX_W-1:0]  r_first;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cpu_if_timeout_ch #(
            .CNT_W          (CNT_W),
            .RESTART_ON_REQ (RESTART_ON_REQ)
        ) u_ch (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_limit      (bus.limit),
            .i_req        (bus.req[g]),
            .i_ack        (bus.ack[g]),
            .i_clr        (bus.clr[g]),
            .o_busy       (w_busy[g]),
            .o_pulse      (w_pulse[g]),
            .o_sticky     (w_sticky[g]),
            .o_sticky_nxt (w_sticky_nxt[g]),
            .o_state      (w_state[g])
        );
    end

    // Built from next-state stickies so the registered summary lines up with timeout_sticky.
    always_comb begin
        w_first = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_sticky_nxt[i]) w_first = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_any   <= 1'b0;
            r_first <= '0;
        end else begin
            r_any   <= |w_sticky_nxt;
            r_first <= w_first;
        end
    end

    assign bus.busy           = w_busy;
    assign bus.timeout_pulse  = w_pulse;
    assign bus.timeout_sticky = w_sticky;
    assign bus.any_timeout    = r_any;
    assign bus.first_ch       = r_first;
    assign bus.dbg_state      = w_state;

endmodule

// File: tb/tb_cpu_if_timeout_mon.sv
// Directed bench for cpu_if_timeout_mon: two instances (restart-on-req off / on) share one stimulus.
// Expected values are hand-derived cycle by cycle from the channel behaviour.
module tb_cpu_if_timeout_mon;
    import cpu_if_timeout_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] limit;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] clr;
    logic [3:0] seen_pulse;
    int         n_vec  = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    cpu_if_timeout_mon_if #(.NUM_CH(4), .CNT_W(8)) bus0 ();
    cpu_if_timeout_mon_if #(.NUM_CH(4), .CNT_W(8)) bus1 ();

    assign bus0.limit = limit;
    assign bus0.req   = req;
    assign bus0.ack   = ack;
    assign bus0.clr   = clr;
    assign bus1.limit = limit;
    assign bus1.req   = req;
    assign bus1.ack   = ack;
    assign bus1.clr   = clr;

    cpu_if_timeout_mon #(.NUM_CH(4), .CNT_W(8), .RESTART_ON_REQ(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    cpu_if_timeout_mon #(.NUM_CH(4), .CNT_W(8), .RESTART_ON_REQ(1'b1)) dut_r (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle 1 time unit past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] mask);
        req = mask;
        tick();
        req = '0;
    endtask

    task automatic drive_clr(input logic [3:0] mask);
        clr = mask;
        tick();
        clr = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(bus0.busy),           0);
        chk({tag, "_pulse"},  32'(bus0.timeout_pulse),  0);
        chk({tag, "_sticky"}, 32'(bus0.timeout_sticky), 0);
        chk({tag, "_any"},    32'(bus0.any_timeout),    0);
        chk({tag, "_first"},  32'(bus0.first_ch),       0);
    endtask

    initial begin
        reset = 1'b1;
        limit = 8'd4;
        req   = '0;
        ack   = '0;
        clr   = '0;
        seen_pulse = '0;
        tick();
        tick();
        chk_all_zero("rst");
        chk("rst_state", 32'(bus0.dbg_state[0]), 32'(IDLE));
        reset = 1'b0;

        // Basic timeout with limit 4 on channel 0
        drive_req(4'b0001);
        chk("t1_busy_e0", 32'(bus0.busy), 1);
        chk("t1_state_e0", 32'(bus0.dbg_state[0]), 32'(WAIT));
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_busy", 32'(bus0.busy), 1);
            chk("t1_nopulse", 32'(bus0.timeout_pulse), 0);
        end
        tick();
        chk("t1_pulse_e4", 32'(bus0.timeout_pulse), 1);
        chk("t1_busy_e4", 32'(bus0.busy), 0);
        chk("t1_sticky_e4", 32'(bus0.timeout_sticky), 1);
        chk("t1_any_e4", 32'(bus0.any_timeout), 1);
        chk("t1_first_e4", 32'(bus0.first_ch), 0);
        tick();
        chk("t1_pulse_once", 32'(bus0.timeout_pulse), 0);
        chk("t1_sticky_hold", 32'(bus0.timeout_sticky), 1);
        chk("t1_any_hold", 32'(bus0.any_timeout), 1);
        drive_clr(4'b0001);
        chk("t1_clr_sticky", 32'(bus0.timeout_sticky), 0);
        chk("t1_clr_any", 32'(bus0.any_timeout), 0);

        // ack on the expiry edge of channel 1 wins
        drive_req(4'b0010);
        tick();
        tick();
        tick();
        chk("t2_busy_e3", 32'(bus0.busy), 'h2);
        ack = 4'b0010;
        tick();
        ack = '0;
        chk("t2_busy_e4", 32'(bus0.busy), 0);
        chk("t2_pulse_e4", 32'(bus0.timeout_pulse), 0);
        chk("t2_sticky_e4", 32'(bus0.timeout_sticky), 0);
        tick();
        chk("t2_pulse_e5", 32'(bus0.timeout_pulse), 0);

        // limit 0 never expires
        limit = 8'd0;
        drive_req(4'b0100);
        for (int k = 0; k < 300; k++) begin
            tick();
            seen_pulse = seen_pulse | bus0.timeout_pulse;
        end
        chk("t3_busy", 32'(bus0.busy), 'h4);
        chk("t3_sticky", 32'(bus0.timeout_sticky), 0);
        chk("t3_no_pulse", 32'(seen_pulse), 0);
        ack = 4'b0100;
        tick();
        ack = '0;
        chk("t3_ack_idle", 32'(bus0.busy), 0);

        // Channels 1 and 3 expire together
        limit = 8'd3;
        drive_req(4'b1010);
        tick();
        tick();
        chk("t4_busy_e2", 32'(bus0.busy), 'hA);
        tick();
        chk("t4_pulse", 32'(bus0.timeout_pulse), 'hA);
        chk("t4_sticky", 32'(bus0.timeout_sticky), 'hA);
        chk("t4_first", 32'(bus0.first_ch), 1);
        chk("t4_any", 32'(bus0.any_timeout), 1);
        req = 4'b1010;
        ack = 4'b1010;
        tick();
        req = '0;
        ack = '0;
        chk("t4_to_ignores_req_ack", 32'(bus0.timeout_sticky), 'hA);
        chk("t4_to_busy", 32'(bus0.busy), 0);
        drive_clr(4'b0010);
        chk("t4_first_after_clr1", 32'(bus0.first_ch), 3);
        chk("t4_sticky_after_clr1", 32'(bus0.timeout_sticky), 'h8);
        chk("t4_any_after_clr1", 32'(bus0.any_timeout), 1);
        drive_clr(4'b1000);
        chk("t4_any_after_clr3", 32'(bus0.any_timeout), 0);
        chk("t4_first_after_clr3", 32'(bus0.first_ch), 0);

        // Restart-on-req: req at edges 0 and 3, limit 5
        limit = 8'd5;
        drive_req(4'b0001);
        tick();
        tick();
        drive_req(4'b0001);
        tick();
        tick();
        chk("t5_norestart_pulse_e5", 32'(bus0.timeout_pulse), 1);
        chk("t5_restart_nopulse_e5", 32'(bus1.timeout_pulse), 0);
        chk("t5_restart_busy_e5", 32'(bus1.busy), 1);
        tick();
        tick();
        chk("t5_restart_nopulse_e7", 32'(bus1.timeout_pulse), 0);
        tick();
        chk("t5_restart_pulse_e8", 32'(bus1.timeout_pulse), 1);
        chk("t5_restart_sticky_e8", 32'(bus1.timeout_sticky), 1);
        chk("t5_restart_state", 32'(bus1.dbg_state[0]), 32'(TIMEOUT));
        drive_clr(4'b0001);

        // limit 2: ack on the expiry edge again, other channel
        limit = 8'd2;
        drive_req(4'b0001);
        tick();
        ack = 4'b0001;
        tick();
        ack = '0;
        chk("t6_ack_wins_pulse", 32'(bus0.timeout_pulse), 0);
        chk("t6_ack_wins_busy", 32'(bus0.busy), 0);
        chk("t6_ack_wins_any", 32'(bus0.any_timeout), 0);

        // Lowering limit below the running count expires on the next edge
        limit = 8'd10;
        drive_req(4'b0001);
        repeat (4) tick();
        chk("t7_busy_before", 32'(bus0.busy), 1);
        limit = 8'd2;
        tick();
        chk("t7_live_limit_pulse", 32'(bus0.timeout_pulse), 1);
        drive_clr(4'b0001);

        // limit 1: expires on the first edge after the request
        limit = 8'd1;
        drive_req(4'b0100);
        chk("t7_lim1_busy", 32'(bus0.busy), 'h4);
        tick();
        chk("t7_lim1_pulse", 32'(bus0.timeout_pulse), 'h4);
        chk("t7_lim1_first", 32'(bus0.first_ch), 2);
        drive_clr(4'b0100);

        // Reset mid-wait, then in TIMEOUT
        limit = 8'd4;
        drive_req(4'b0001);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("t8_rst_wait");
        drive_req(4'b0001);
        chk("t8_req_after_rst", 32'(bus0.busy), 1);
        repeat (4) tick();
        chk("t8_sticky_before_rst", 32'(bus0.timeout_sticky), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("t8_rst_to");
        chk("t8_rst_to_r", 32'(bus1.timeout_sticky), 0);

        // clr together with req does not start; clr aborts a wait
        req = 4'b0001;
        clr = 4'b0001;
        tick();
        req = '0;
        clr = '0;
        chk("t9_clr_req_busy", 32'(bus0.busy), 0);
        drive_req(4'b1000);
        drive_clr(4'b1000);
        chk("t9_clr_wait_busy", 32'(bus0.busy), 0);
        repeat (6) tick();
        chk("t9_clr_wait_sticky", 32'(bus0.timeout_sticky), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
